// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for a pixel sensor array: erase, expose, convert (digital ramp), row read.
// Define PIXEL_CTRL_CONTINUOUS_EN to restart each frame automatically after frame_done.
module pixel_array_ctrl #(
  parameter int PIXEL_BITS   = 8,
  parameter int ROWS         = 2,
  parameter int ERASE_CYCLES = 5,
  parameter int READ_CYCLES  = 5,
  parameter int EXP_W        = 8,
  localparam int ROW_W       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [EXP_W-1:0]      expose_cycles,
  output logic                  busy,
  output logic                  erase,
  output logic                  expose,
  output logic                  convert,
  output logic [PIXEL_BITS-1:0] digital_ramp,
  output logic [ROWS-1:0]       read_row,
  output logic [ROW_W-1:0]      row_idx,
  output logic                  row_strobe,
  output logic                  frame_done
);

  // state   | meaning
  // IDLE    | waiting for start (or frame_done restart in continuous mode)
  // ERASE   | erase high for ERASE_CYCLES
  // GAP     | one cycle all controls low; gap_next selects the following phase
  // EXPOSE  | expose high for the latched exposure count
  // CONVERT | convert high, ramp 0 .. 2^PIXEL_BITS-1
  // READ    | rows 0 .. ROWS-1, READ_CYCLES each
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ERASE   = 3'd1;
  localparam logic [2:0] S_GAP     = 3'd2;
  localparam logic [2:0] S_EXPOSE  = 3'd3;
  localparam logic [2:0] S_CONVERT = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;

`ifdef PIXEL_CTRL_CONTINUOUS_EN
  localparam bit CONTINUOUS = 1'b1;
`else
  localparam bit CONTINUOUS = 1'b0;
`endif

  localparam int NCONV = 1 << PIXEL_BITS;
  localparam int NEXP  = 1 << EXP_W;
  localparam int M1    = (ERASE_CYCLES > READ_CYCLES) ? ERASE_CYCLES : READ_CYCLES;
  localparam int M2    = (NEXP > NCONV) ? NEXP : NCONV;
  localparam int MAXC  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = $clog2(MAXC) + 1;

  logic [2:0]       state, state_n;
  logic [2:0]       gap_next, gap_next_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [ROW_W-1:0] row, row_n;
  logic [EXP_W-1:0] exp_lat, exp_n;
  logic             pend, pend_n;
  logic             done_n;
  logic [EXP_W-1:0] exp_in;

  assign exp_in = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;

  always_comb begin
    state_n    = state;
    gap_next_n = gap_next;
    cnt_n      = cnt;
    row_n      = row;
    exp_n      = exp_lat;
    pend_n     = 1'b0;
    done_n     = 1'b0;
    if (abort && state != S_IDLE) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      row_n   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Accepted start spends one cycle in IDLE so erase lands two edges after start.
          if (CONTINUOUS && frame_done && !abort) begin
            state_n = S_ERASE;
            cnt_n   = CNT_W'(ERASE_CYCLES - 1);
            exp_n   = exp_in;
          end else if (pend) begin
            state_n = S_ERASE;
            cnt_n   = CNT_W'(ERASE_CYCLES - 1);
          end else if (start) begin
            pend_n = 1'b1;
            exp_n  = exp_in;
          end
        end
        S_ERASE: begin
          if (cnt == '0) begin
            state_n    = S_GAP;
            gap_next_n = S_EXPOSE;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_GAP: begin
          state_n = gap_next;
          case (gap_next)
            S_EXPOSE:  cnt_n = CNT_W'(exp_lat) - CNT_W'(1);
            S_CONVERT: cnt_n = CNT_W'(NCONV - 1);
            default: begin
              cnt_n = CNT_W'(READ_CYCLES - 1);
              row_n = '0;
            end
          endcase
        end
        S_EXPOSE: begin
          if (cnt == '0) begin
            state_n    = S_GAP;
            gap_next_n = S_CONVERT;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_CONVERT: begin
          if (cnt == '0) begin
            state_n    = S_GAP;
            gap_next_n = S_READ;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        S_READ: begin
          if (cnt != '0) begin
            cnt_n = cnt - CNT_W'(1);
          end else if (row == ROW_W'(ROWS - 1)) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
            row_n   = '0;
          end else begin
            row_n = row + ROW_W'(1);
            cnt_n = CNT_W'(READ_CYCLES - 1);
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      gap_next     <= S_EXPOSE;
      cnt          <= '0;
      row          <= '0;
      exp_lat      <= EXP_W'(1);
      pend         <= 1'b0;
      busy         <= 1'b0;
      erase        <= 1'b0;
      expose       <= 1'b0;
      convert      <= 1'b0;
      digital_ramp <= '0;
      read_row     <= '0;
      row_idx      <= '0;
      row_strobe   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      state        <= state_n;
      gap_next     <= gap_next_n;
      cnt          <= cnt_n;
      row          <= row_n;
      exp_lat      <= exp_n;
      pend         <= pend_n;
      busy         <= (state_n != S_IDLE);
      erase        <= (state_n == S_ERASE);
      expose       <= (state_n == S_EXPOSE);
      convert      <= (state_n == S_CONVERT);
      if (state_n == S_CONVERT)
        digital_ramp <= (state == S_CONVERT) ? digital_ramp + PIXEL_BITS'(1) : '0;
      else
        digital_ramp <= '0;
      read_row     <= (state_n == S_READ) ? (ROWS'(1) << row_n) : '0;
      row_idx      <= (state_n == S_READ) ? row_n : '0;
      row_strobe   <= (state_n == S_READ) && (cnt_n == '0);
      frame_done   <= done_n;
    end
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Self-checking bench for pixel_array_ctrl (PIXEL_BITS=4, ROWS=3, ERASE_CYCLES=2, READ_CYCLES=2).
// Expected traces come from a cycle-index model of the frame timeline.
module tb_pixel_array_ctrl;
  localparam int PB = 4;
  localparam int NR = 3;
  localparam int EC = 2;
  localparam int RC = 2;
  localparam int EW = 8;
  localparam int NC = 1 << PB;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic [EW-1:0] expose_cycles;
  logic          busy, erase, expose, convert, row_strobe, frame_done;
  logic [PB-1:0] digital_ramp;
  logic [NR-1:0] read_row;
  logic [1:0]    row_idx;
  logic [14:0]   obs;

  int checks = 0;
  int passes = 0;
  int next_x = 1;

  pixel_array_ctrl #(.PIXEL_BITS(PB), .ROWS(NR), .ERASE_CYCLES(EC), .READ_CYCLES(RC), .EXP_W(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .expose_cycles(expose_cycles),
    .busy(busy), .erase(erase), .expose(expose), .convert(convert), .digital_ramp(digital_ramp),
    .read_row(read_row), .row_idx(row_idx), .row_strobe(row_strobe), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  assign obs = {busy, erase, expose, convert, digital_ramp, read_row, row_idx, row_strobe, frame_done};

  // Cycle k counts from the edge that sampled start (k=0 is the cycle right after it).
  function automatic int done_k(input int x);
    return EC + x + NC + NR * RC + 4;
  endfunction

  function automatic logic [14:0] exp_vec(input int k, input int x);
    logic b, er, ex, cv, st, fd;
    logic [PB-1:0] rp;
    logic [NR-1:0] rr;
    logic [1:0] ri;
    int ex_s, cv_s, rd_s, j;
    ex_s = EC + 2;
    cv_s = ex_s + x + 1;
    rd_s = cv_s + NC + 1;
    b = (k >= 1) && (k < done_k(x));
    er = (k >= 1) && (k <= EC);
    ex = (k >= ex_s) && (k < ex_s + x);
    cv = (k >= cv_s) && (k < cv_s + NC);
    rp = cv ? PB'(k - cv_s) : '0;
    rr = '0; ri = '0; st = 1'b0;
    if (k >= rd_s && k < rd_s + NR * RC) begin
      j  = k - rd_s;
      rr = NR'(1) << (j / RC);
      ri = 2'(j / RC);
      st = ((j % RC) == RC - 1);
    end
    fd = (k == done_k(x));
    return {b, er, ex, cv, rp, rr, ri, st, fd};
  endfunction

  task automatic run_frame(input string name, input int x_in, input int mid_exp, input int abort_k,
                           input int reset_k, input bit pre_started, input bit chain);
    int x, stop_k, last;
    int n_er, n_ex, n_cv, n_rd, n_st, n_b, n_fd;
    logic [14:0] e;
    x = (x_in == 0) ? 1 : x_in;
    stop_k = (abort_k >= 0) ? abort_k : reset_k;
    last = chain ? done_k(x) : ((stop_k >= 0) ? stop_k + 4 : done_k(x) + 2);
    n_er = 0; n_ex = 0; n_cv = 0; n_rd = 0; n_st = 0; n_b = 0; n_fd = 0;
    if (!pre_started) begin
      expose_cycles = EW'(x_in);
      start = 1'b1;
    end
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      e = (stop_k >= 0 && k > stop_k) ? 15'd0 : exp_vec(k, x);
      checks++;
      if (obs !== e) $display("FAIL %s k=%0d got=%h expected=%h", name, k, obs, e);
      else passes++;
      n_er += int'(erase); n_ex += int'(expose); n_cv += int'(convert);
      n_rd += int'(|read_row); n_st += int'(row_strobe); n_b += int'(busy); n_fd += int'(frame_done);
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      if (k == 0) expose_cycles = (mid_exp >= 0) ? EW'(mid_exp) : EW'($urandom_range(0, 255));
      if (k == abort_k) abort = 1'b1;
      if (k == reset_k) reset = 1'b1;
      if ((stop_k < 0 || k < stop_k) && k >= 2 && k <= done_k(x) - 2 && $urandom_range(0, 7) == 0)
        start = 1'b1;
      if (chain && k == done_k(x)) begin
        start = 1'b1;
        expose_cycles = EW'(next_x);
      end
    end
    if (stop_k < 0) begin
      checks++; if (n_er !== EC) $display("FAIL %s erase_count got=%0d expected=%0d", name, n_er, EC); else passes++;
      checks++; if (n_ex !== x) $display("FAIL %s expose_count got=%0d expected=%0d", name, n_ex, x); else passes++;
      checks++; if (n_cv !== NC) $display("FAIL %s convert_count got=%0d expected=%0d", name, n_cv, NC); else passes++;
      checks++; if (n_rd !== NR * RC) $display("FAIL %s read_count got=%0d expected=%0d", name, n_rd, NR * RC); else passes++;
      checks++; if (n_st !== NR) $display("FAIL %s strobe_count got=%0d expected=%0d", name, n_st, NR); else passes++;
      checks++; if (n_b !== done_k(x) - 1) $display("FAIL %s busy_count got=%0d expected=%0d", name, n_b, done_k(x) - 1); else passes++;
      checks++; if (n_fd !== 1) $display("FAIL %s done_count got=%0d expected=1", name, n_fd); else passes++;
    end else begin
      checks++; if (n_fd !== 0) $display("FAIL %s done_after_stop got=%0d expected=0", name, n_fd); else passes++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; expose_cycles = '0;
    repeat (3) @(negedge clk);
    checks++; if (obs !== 15'd0) $display("FAIL reset_held got=%h expected=0", obs); else passes++;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (obs !== 15'd0) $display("FAIL idle_cycle%0d got=%h expected=0", i, obs); else passes++;
    end
  endtask

  task automatic test_basic();
    run_frame("basic_x5", 5, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_zero_exposure();
    run_frame("zero_exp", 0, 200, -1, -1, 1'b0, 1'b0);
    run_frame("after_zero_x3", 3, 200, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_abort_convert();
    run_frame("abort_ramp7", 4, -1, EC + 4 + 3 + 7, -1, 1'b0, 1'b0);
    run_frame("after_abort", 2, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_wins();
    expose_cycles = 8'd4; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    checks++; if (obs !== 15'd0) $display("FAIL start_wins_k0 got=%h expected=0", obs); else passes++;
    @(negedge clk);
    checks++; if ({busy, erase} !== 2'b11) $display("FAIL start_wins_erase got=%b expected=11", {busy, erase}); else passes++;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (obs !== 15'd0) $display("FAIL start_wins_abort got=%h expected=0", obs); else passes++;
  endtask

  task automatic test_reset_read();
    run_frame("reset_row1", 6, -1, -1, EC + 6 + NC + 4 + RC, 1'b0, 1'b0);
    run_frame("after_reset", 1, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int x, ak;
    for (int i = 0; i < 6; i++) begin
      x = $urandom_range(0, 12);
      ak = ($urandom_range(0, 1) == 1) ? $urandom_range(1, done_k((x == 0) ? 1 : x) - 1) : -1;
      run_frame($sformatf("rand%0d_x%0d_ab%0d", i, x, ak), x, -1, ak, -1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    next_x = 7;
    run_frame("b2b_first", 3, -1, -1, -1, 1'b0, 1'b1);
    next_x = 2;
    run_frame("b2b_second", 7, -1, -1, -1, 1'b1, 1'b1);
    run_frame("b2b_third", 2, -1, -1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_continuous();
    int waited;
    expose_cycles = 8'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int f = 0; f < 3; f++) begin
      waited = 0;
      while (frame_done !== 1'b1 && waited < 200) begin
        @(negedge clk);
        waited++;
      end
      checks++; if (frame_done !== 1'b1) $display("FAIL cont_done%0d got=timeout expected=frame_done", f); else passes++;
      @(negedge clk);
      checks++; if ({busy, erase} !== 2'b11) $display("FAIL cont_restart%0d got=%b expected=11", f, {busy, erase}); else passes++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (obs !== 15'd0) $display("FAIL cont_abort got=%h expected=0", obs); else passes++;
  endtask

  initial begin
    test_reset();
`ifdef PIXEL_CTRL_CONTINUOUS_EN
    test_continuous();
`else
    test_basic();
    test_zero_exposure();
    test_abort_convert();
    test_start_wins();
    test_reset_read();
    test_random();
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
